// File: rtl/led_sequence_player.sv
// LED sequence player: replays a stored colour sequence with timed on/gap phases.
// The sequence is snapshotted at start; all outputs come straight from registers.
module led_sequence_player #(
  parameter int N_PLAYERS  = 2,
  parameter int SEQ_LEN    = 8,
  parameter int N_LEDS     = 4,
  parameter int ON_CYCLES  = 40_000_000,
  parameter int OFF_CYCLES = 10_000_000,
  parameter int CW = $clog2(N_LEDS),
  parameter int PW = $clog2(N_PLAYERS),
  parameter int LW = $clog2(SEQ_LEN+1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [PW-1:0]                  i_player,
  input  logic [LW-1:0]                  i_len,
  input  logic [N_PLAYERS*SEQ_LEN*CW-1:0] i_seq,
  output logic [N_LEDS-1:0]              o_led,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [LW-1:0]                  o_step
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ?
                        ON_CYCLES : OFF_CYCLES;
  localparam int CNTW = $clog2(MAXC+1);
  localparam int SW   = SEQ_LEN*CW;

  typedef enum logic [1:0] {
    S_IDLE, S_ON, S_GAP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]     step_q, step_d;
  logic [LW-1:0]     len_q, len_d;
  logic [SW-1:0]     seq_q, seq_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  int                pidx;
  logic [SW-1:0]     snap;
  logic [LW-1:0]     eff_len;
  logic [CW-1:0]     col;
  logic              last;

  // Out-of-range player falls back to player 0
  assign pidx    = (int'(i_player) >= N_PLAYERS) ?
                   0 : int'(i_player);
  assign snap    = i_seq[pidx*SW +: SW];
  assign eff_len = (i_len > LW'(SEQ_LEN)) ?
                   LW'(SEQ_LEN) : i_len;
  assign last    = (step_q + LW'(1)) >= len_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    len_d   = len_q;
    seq_d   = seq_q;
    led_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    col     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          seq_d  = snap;
          len_d  = eff_len;
          step_d = '0;
          if (eff_len == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_ON;
            cnt_d   = CNTW'(ON_CYCLES-1);
          end
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNTW'(OFF_CYCLES-1);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_ON;
            step_d  = step_q + LW'(1);
            cnt_d   = CNTW'(ON_CYCLES-1);
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_abort) begin
      state_d = S_IDLE;
      step_d  = '0;
      cnt_d   = '0;
    end
    // Outputs are decoded from the next state so they register with it
    col    = seq_d[int'(step_d)*CW +: CW];
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_ON && int'(col) < N_LEDS)
      led_d = N_LEDS'(1) << col;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      seq_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_step = step_q;

endmodule

// File: tb/tb_led_sequence_player.sv
// Bench for led_sequence_player: per-cycle timeline model plus
// hand-computed literal checks at key cycles.
module tb_led_sequence_player;

  localparam int NP  = 2;
  localparam int SL  = 8;
  localparam int NL  = 4;
  localparam int ONC = 4;
  localparam int OFC = 2;
  localparam int CW  = 2;
  localparam int PW  = 1;
  localparam int LW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [PW-1:0]     player = '0;
  logic [LW-1:0]     len = '0;
  logic [NP*SL*CW-1:0] seq = '0;
  logic [NL-1:0]     led;
  logic              busy;
  logic              done;
  logic [LW-1:0]     step;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } exp_t;

  exp_t exp_q[$];

  led_sequence_player #(
    .N_PLAYERS(NP), .SEQ_LEN(SL), .N_LEDS(NL),
    .ON_CYCLES(ONC), .OFF_CYCLES(OFC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_abort(abort), .i_player(player), .i_len(len),
    .i_seq(seq), .o_led(led), .o_busy(busy),
    .o_done(done), .o_step(step)
  );

  always #5 clk = ~clk;

  // Whole playback timeline expanded from the rules at start time
  task automatic plan_start();
    int p, n, c;
    exp_t e;
    p = (int'(player) >= NP) ? 0 : int'(player);
    n = (int'(len) > SL) ? SL : int'(len);
    for (int s = 0; s < n; s++) begin
      c = int'(seq[(p*SL+s)*CW +: CW]);
      e.busy = 1'b1;
      e.done = 1'b0;
      e.step = 4'(s);
      e.led  = (c < NL) ? 4'(1 << c) : 4'd0;
      for (int k = 0; k < ONC; k++) exp_q.push_back(e);
      e.led = 4'd0;
      for (int k = 0; k < OFC; k++) exp_q.push_back(e);
    end
    e.led  = 4'd0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.step = (n == 0) ? 4'd0 : 4'(n-1);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst || abort)
      exp_q.delete();
    else if (exp_q.size() > 0)
      void'(exp_q.pop_front());
    else if (start)
      plan_start();
  end

  always @(negedge clk) begin
    exp_t e, g;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q[0] : exp_t'(0);
      g = {led, busy, done, step};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL model t=%0t got led=%b busy=%b done=%b step=%0d exp led=%b busy=%b done=%b step=%0d",
          $time, g.led, g.busy, g.done, g.step,
          e.led, e.busy, e.done, e.step);
      end
    end
  end

  task automatic chk(string n, int got, int ex);
    tests++;
    if (got !== ex) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               n, cyc, got, ex);
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_col(int p, int s, int c);
    seq[(p*SL+s)*CW +: CW] = CW'(c);
  endtask

  task automatic go();
    start = 1'b1;
    cyc = 0;
    next();
    start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) next();
  endtask

  task automatic load_a();
    seq = '0;
    set_col(0, 0, 2);
    set_col(0, 1, 0);
    set_col(0, 2, 3);
    player = 1'b0;
    len = 4'd3;
  endtask

  initial begin
    int bcnt, smax, dcnt;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_led", int'(led), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step), 0);
    rst = 1'b0;

    // Basic playback, repeated start at cycle 5 ignored
    load_a();
    go();
    while (cyc < 22) begin
      case (cyc)
        1:  chk("A_led1", int'(led), 4);
        4:  chk("A_led4", int'(led), 4);
        5:  begin chk("A_led5", int'(led), 0); start = 1'b1; end
        6:  start = 1'b0;
        7:  chk("A_led7", int'(led), 1);
        13: chk("A_led13", int'(led), 8);
        19: chk("A_done19", int'(done), 1);
        20: chk("A_busy20", int'(busy), 0);
        default: ;
      endcase
      next();
    end

    // Player 1, len 9 clamps to 8 steps
    for (int s = 0; s < SL; s++) set_col(1, s, (s*3+1) % 4);
    player = 1'b1;
    len = 4'd9;
    go();
    bcnt = 0;
    smax = 0;
    while (cyc < 56) begin
      if (busy) bcnt++;
      if (int'(step) > smax) smax = int'(step);
      next();
    end
    chk("B_busy_cycles", bcnt, 49);
    chk("B_step_max", smax, 7);

    // Abort at cycle 8, restart at cycle 10
    load_a();
    go();
    while (cyc < 34) begin
      case (cyc)
        8:  abort = 1'b1;
        9:  begin
          abort = 1'b0;
          chk("C_led9", int'(led), 0);
          chk("C_busy9", int'(busy), 0);
          chk("C_done9", int'(done), 0);
        end
        10: start = 1'b1;
        11: begin
          start = 1'b0;
          chk("C_led11", int'(led), 4);
        end
        default: ;
      endcase
      next();
    end

    // Zero length
    len = 4'd0;
    go();
    chk("D_done1", int'(done), 1);
    chk("D_led1", int'(led), 0);
    next();
    chk("D_busy2", int'(busy), 0);
    idle(2);

    // Reset at cycle 10, start on first cycle after
    load_a();
    go();
    dcnt = 0;
    while (cyc < 34) begin
      if (cyc >= 11 && cyc < 31 && done) dcnt++;
      case (cyc)
        10: begin
          chk("E_step10", int'(step), 1);
          rst = 1'b1;
        end
        11: begin
          rst = 1'b0;
          chk("E_out11", int'({led, busy, done, step}), 0);
          start = 1'b1;
        end
        12: begin
          start = 1'b0;
          chk("E_led12", int'(led), 4);
        end
        default: ;
      endcase
      next();
    end
    chk("E_done_after_rst", dcnt, 1);

    // Snapshot: inputs change at cycle 3
    seq = '0;
    set_col(0, 0, 1);
    set_col(0, 1, 3);
    set_col(0, 2, 2);
    player = 1'b0;
    len = 4'd3;
    go();
    while (cyc < 22) begin
      case (cyc)
        3: begin
          seq = '0;
          player = 1'b1;
          len = 4'd1;
        end
        7:  chk("F_led7", int'(led), 8);
        13: chk("F_led13", int'(led), 4);
        19: chk("F_done19", int'(done), 1);
        default: ;
      endcase
      next();
    end

    // Start and abort together: abort wins
    load_a();
    start = 1'b1;
    abort = 1'b1;
    cyc = 0;
    next();
    start = 1'b0;
    abort = 1'b0;
    chk("G_busy1", int'(busy), 0);
    idle(2);

    // Start during DONE cycle ignored
    len = 4'd1;
    go();
    while (cyc < 11) begin
      case (cyc)
        7: begin
          chk("H_done7", int'(done), 1);
          start = 1'b1;
        end
        8: begin
          start = 1'b0;
          chk("H_busy8", int'(busy), 0);
        end
        9: chk("H_busy9", int'(busy), 0);
        default: ;
      endcase
      next();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
